// File: rtl/enc8b10b_rd_sel.sv
// 8b/10b running-disparity code selector between the RD-/RD+ ROMs and the lane.
// Two stages: ROM read in flight (S1) and an output register with back-pressure.
module enc8b10b_rd_sel #(
  parameter logic RD_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_k,
  output logic [7:0] rom_addr,
  output logic       rom_rd_en,
  output logic       rom_k,
  input  logic [9:0] rom_minus_code,
  input  logic [9:0] rom_plus_code,
  input  logic       rom_minus_kerr,
  input  logic       rom_plus_kerr,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [9:0] m_data,
  output logic       m_k_error,
  output logic       m_disp_error,
  output logic       o_rd
);

  logic       s1_valid;
  logic       k_q;
  logic [7:0] addr_q;
  logic       advance;
  logic       issue;
  logic [9:0] sel_code;
  logic       kerr;
  logic [3:0] n;
  logic       rd_nxt;
  logic       derr_nxt;

  function automatic logic [3:0] ones(input logic [9:0] c);
    logic [3:0] acc;
    acc = '0;
    for (int i = 0; i < 10; i++) acc = acc + {3'b0, c[i]};
    return acc;
  endfunction

  assign advance   = s1_valid & (~m_valid | m_ready);
  assign s_ready   = ~rst & ~i_clear & (~s1_valid | advance);
  assign issue     = s_valid & s_ready;
  assign rom_rd_en = issue;
  // Hold the address when idle so the re-registering k path keeps its code
  assign rom_addr  = issue ? s_data : addr_q;
  assign rom_k     = k_q;

  assign sel_code = o_rd ? rom_plus_code : rom_minus_code;
  assign kerr     = k_q & (o_rd ? rom_plus_kerr : rom_minus_kerr);
  assign n        = ones(sel_code);

  always_comb begin
    rd_nxt   = o_rd;
    derr_nxt = 1'b0;
    if (!kerr) begin
      case (n)
        4'd6: begin
          rd_nxt   = 1'b1;
          derr_nxt = o_rd;
        end
        4'd4: begin
          rd_nxt   = 1'b0;
          derr_nxt = ~o_rd;
        end
        4'd5:    derr_nxt = 1'b0;
        default: derr_nxt = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      addr_q       <= '0;
      k_q          <= 1'b0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_k_error    <= 1'b0;
      m_disp_error <= 1'b0;
      o_rd         <= RD_INIT;
    end else if (i_clear) begin
      s1_valid <= 1'b0;
      m_valid  <= 1'b0;
      o_rd     <= RD_INIT;
    end else begin
      if (issue) begin
        s1_valid <= 1'b1;
        addr_q   <= s_data;
        k_q      <= s_k;
      end else if (advance) begin
        s1_valid <= 1'b0;
      end
      if (advance) begin
        m_valid      <= 1'b1;
        m_data       <= kerr ? 10'd0 : sel_code;
        m_k_error    <= kerr;
        m_disp_error <= derr_nxt;
        o_rd         <= rd_nxt;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_enc8b10b_rd_sel.sv
// Bench for enc8b10b_rd_sel: stub RD-/RD+ ROMs, vector table, scoreboard queue,
// and hand sequences for latency, stall, clear and mid-stream reset.
module tb_enc8b10b_rd_sel;

  typedef struct packed {
    logic [9:0] code;
    logic       kerr;
    logic       derr;
    logic       rd;
  } exp_t;

  typedef struct packed {
    logic [7:0] d;
    logic       k;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_clear;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_k;
  logic [7:0] rom_addr;
  logic       rom_rd_en;
  logic       rom_k;
  logic [9:0] rom_minus_code;
  logic [9:0] rom_plus_code;
  logic       rom_minus_kerr;
  logic       rom_plus_kerr;
  logic       m_valid;
  logic       m_ready;
  logic [9:0] m_data;
  logic       m_k_error;
  logic       m_disp_error;
  logic       o_rd;

  int   checks = 0;
  int   fails  = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[16];
  logic [7:0] rom_a = 8'h00;
  logic [7:0] a_hold;

  always #5 clk = ~clk;

  enc8b10b_rd_sel #(.RD_INIT(1'b0)) dut (
    .clk(clk), .rst(rst), .i_clear(i_clear),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_k(s_k),
    .rom_addr(rom_addr), .rom_rd_en(rom_rd_en), .rom_k(rom_k),
    .rom_minus_code(rom_minus_code), .rom_plus_code(rom_plus_code),
    .rom_minus_kerr(rom_minus_kerr), .rom_plus_kerr(rom_plus_kerr),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_k_error(m_k_error), .m_disp_error(m_disp_error), .o_rd(o_rd)
  );

  // Stub ROMs: registered address, k applied at the output
  function automatic logic [10:0] lut(input logic [7:0] a,
                                      input logic k,
                                      input logic plus);
    logic [9:0] c;
    if (k) begin
      if (a == 8'hBC)
        return {1'b0, plus ? 10'b1100000101 : 10'b0011111010};
      return 11'h400;
    end
    case (a)
      8'h00:   c = plus ? 10'b0110001011 : 10'b1001110100;
      8'hEE:   c = 10'b1111111111;
      8'hEF:   c = 10'b0000001111;
      8'hED:   c = 10'b1111110000;
      default: c = {a[4:0], ~a[4:0]};
    endcase
    return {1'b0, c};
  endfunction

  always @(posedge clk) if (rom_rd_en) rom_a <= rom_addr;
  assign {rom_minus_kerr, rom_minus_code} = lut(rom_a, rom_k, 1'b0);
  assign {rom_plus_kerr, rom_plus_code}   = lut(rom_a, rom_k, 1'b1);

  function automatic exp_t mke(input logic [9:0] c, input logic ke,
                               input logic de, input logic r);
    exp_t e;
    e.code = c; e.kerr = ke; e.derr = de; e.rd = r;
    return e;
  endfunction

  function automatic vec_t mkv(input logic [7:0] d, input logic k,
                               input exp_t e);
    vec_t v;
    v.d = d; v.k = k; v.e = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic k, input exp_t e);
    int n = 0;
    @(negedge clk);
    s_valid = 1'b1; s_data = d; s_k = k;
    #2;
    while (!s_ready && n < 60) begin
      @(negedge clk); #2; n++;
    end
    if (!s_ready) begin
      checks++; fails++;
      $display("FAIL send_timeout: byte %0h never accepted", d);
    end else begin
      @(posedge clk);
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(negedge clk); n++;
    end
    if (exp_q.size() > 0) begin
      checks++; fails++;
      $display("FAIL %s: %0d symbols missing, expected 0", name, exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; i_clear = 1'b0; s_valid = 1'b0;
    s_data = '0; s_k = 1'b0; m_ready = 1'b1;

    vecs[0]  = mkv(8'hBC, 1, mke(10'b0011111010, 0, 0, 1));
    vecs[1]  = mkv(8'hBC, 1, mke(10'b1100000101, 0, 0, 0));
    vecs[2]  = mkv(8'hB5, 0, mke(10'b1010101010, 0, 0, 0));
    vecs[3]  = mkv(8'hB5, 0, mke(10'b1010101010, 0, 0, 0));
    vecs[4]  = mkv(8'hB5, 0, mke(10'b1010101010, 0, 0, 0));
    vecs[5]  = mkv(8'h00, 0, mke(10'b1001110100, 0, 0, 0));
    vecs[6]  = mkv(8'h00, 0, mke(10'b1001110100, 0, 0, 0));
    vecs[7]  = mkv(8'hBC, 1, mke(10'b0011111010, 0, 0, 1));
    vecs[8]  = mkv(8'h00, 0, mke(10'b0110001011, 0, 0, 1));
    vecs[9]  = mkv(8'h00, 1, mke(10'b0000000000, 1, 0, 1));
    vecs[10] = mkv(8'hEE, 0, mke(10'b1111111111, 0, 1, 1));
    vecs[11] = mkv(8'hEF, 0, mke(10'b0000001111, 0, 0, 0));
    vecs[12] = mkv(8'hEF, 0, mke(10'b0000001111, 0, 1, 0));
    vecs[13] = mkv(8'hED, 0, mke(10'b1111110000, 0, 0, 1));
    vecs[14] = mkv(8'hED, 0, mke(10'b1111110000, 0, 1, 1));
    vecs[15] = mkv(8'hBC, 1, mke(10'b1100000101, 0, 0, 0));

    fork
      forever begin
        @(negedge clk);
        #3;
        if (!rst && m_valid && m_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sym_unexpected: got %b, expected none", m_data);
          end else begin
            mon_e = exp_q.pop_front();
            if ({m_data, m_k_error, m_disp_error, o_rd} !== mon_e) begin
              fails++;
              $display("FAIL sym: got %b k%b d%b rd%b, expected %b k%b d%b rd%b",
                       m_data, m_k_error, m_disp_error, o_rd,
                       mon_e.code, mon_e.kerr, mon_e.derr, mon_e.rd);
            end
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    #2;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_k_error", m_k_error, 0);
    chk("rst_disp_error", m_disp_error, 0);
    chk("rst_o_rd", o_rd, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_rom_k", rom_k, 0);
    @(negedge clk);
    rst = 1'b0;

    // Accept at edge N, visible only after edge N+1
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'hB5; s_k = 1'b0;
    @(posedge clk);
    exp_q.push_back(mke(10'b1010101010, 0, 0, 0));
    @(negedge clk);
    s_valid = 1'b0;
    #1 chk("lat_edge_n", m_valid, 0);
    @(negedge clk);
    #1 chk("lat_edge_n1", m_valid, 1);
    drain("lat_drain");

    for (int i = 0; i < 16; i++) send(vecs[i].d, vecs[i].k, vecs[i].e);
    idle();
    drain("table_drain");

    // Six-byte burst against a blocked output
    @(negedge clk);
    m_ready = 1'b0;
    fork
      begin
        for (int j = 1; j <= 6; j++) begin
          a_hold = 8'(j);
          send(a_hold, 1'b0, mke({a_hold[4:0], ~a_hold[4:0]}, 0, 0, 0));
        end
        idle();
      end
      begin
        repeat (5) @(negedge clk);
        #2;
        chk("stall_s_ready", s_ready, 0);
        chk("stall_m_valid", m_valid, 1);
        chk("stall_m_data", m_data, 10'b0000111110);
        chk("stall_rom_addr", rom_addr, 8'h02);
        chk("stall_rom_rd_en", rom_rd_en, 0);
        @(negedge clk);
        #2;
        chk("stall_rom_addr_hold", rom_addr, 8'h02);
        chk("stall_m_data_hold", m_data, 10'b0000111110);
        @(negedge clk);
        m_ready = 1'b1;
      end
    join
    drain("stall_drain");

    // Flush with both stages full and RD moved to +
    @(negedge clk);
    m_ready = 1'b0;
    send(8'hBC, 1, mke(10'b0011111010, 0, 0, 1));
    send(8'hB5, 0, mke(10'b1010101010, 0, 0, 1));
    @(negedge clk);
    s_data = 8'h77; s_k = 1'b0;
    #2;
    chk("clr_pre_s_ready", s_ready, 0);
    chk("clr_pre_rd", o_rd, 1);
    chk("clr_pre_m_valid", m_valid, 1);
    @(negedge clk);
    i_clear = 1'b1;
    exp_q.delete();
    #2 chk("clr_s_ready", s_ready, 0);
    @(negedge clk);
    i_clear = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    #2;
    chk("clr_m_valid", m_valid, 0);
    chk("clr_o_rd", o_rd, 0);
    send(8'hBC, 1, mke(10'b0011111010, 0, 0, 1));
    idle();
    drain("clr_drain");

    // Reset in the middle of a held burst
    @(negedge clk);
    m_ready = 1'b0;
    send(8'hBC, 1, mke(10'b1100000101, 0, 0, 0));
    send(8'hBC, 1, mke(10'b0011111010, 0, 0, 1));
    @(negedge clk);
    s_valid = 1'b0;
    #2 chk("mrst_pre_rd", o_rd, 0);
    @(negedge clk);
    #2 chk("mrst_pre_m_valid", m_valid, 1);
    rst = 1'b1;
    exp_q.delete();
    #2;
    chk("mrst_m_valid", m_valid, 0);
    chk("mrst_o_rd", o_rd, 0);
    chk("mrst_s_ready", s_ready, 0);
    chk("mrst_m_data", m_data, 0);
    @(negedge clk);
    rst = 1'b0; m_ready = 1'b1;
    send(8'hBC, 1, mke(10'b0011111010, 0, 0, 1));
    idle();
    drain("mrst_drain");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
